spi_cfg_slave: RTL and testbench
================================

# spi_cfg_slave

SPI slave front-end for the DSP datapath's memory-access port. It deserializes 24-bit SPI frames into the single-cycle `msg_in`/`rw` strobe and the stable `mem_addr`/`coeff_in` buses that drive the coefficient and sample memories. For reads, it captures the returned `mem_read_out` byte and serializes it back on `miso` within the same frame. It sits directly upstream of `dsp_top`, in the `clk` domain.

## Interface
- `READ_LAT`, 3: clk cycles from read strobe (`msg_in`=1, `rw`=0) to valid `mem_read_out`.
- `SYNC_STAGES`, 2: flip-flop stages synchronizing `sclk`, `cs_n` and `mosi` into `clk`.
- `clk` input 1: system clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `sclk` input 1: SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to `clk`.
- `cs_n` input 1: active-low chip select; frames the transaction.
- `mosi` input 1: serial data in, MSB first.
- `miso` output 1: serial data out, MSB first; 0 when `cs_n` is high.
- `mem_read_out` input 8: read data returned by `dsp_top`.
- `msg_in` output 1: one-clk access strobe.
- `rw` output 1: 1 = write, 0 = read; valid whenever `msg_in`=1.
- `mem_addr` output 10: global memory address.
- `coeff_in` output 8: write data.
- `addr_err` output 1: sticky flag for a rejected write address (see Configuration).

## Operation
- Frame format, 24 bits: bit 23 = `rw`; bits 22:18 reserved (ignored); bits 17:8 = address; bits 7:0 = write data. For reads, bits 7:0 are don't-care on `mosi` and carry the read byte on `miso`.
- All pins are synchronized through `SYNC_STAGES` flops. Rising and falling edges of `sclk` are detected by comparing the last two synchronized samples.
- `mosi` is sampled on a detected `sclk` rising edge. `miso` is updated on a detected `sclk` falling edge.
- FSM states:
  - IDLE: `cs_n` falling → SHIFT_HDR; bit counter cleared.
  - SHIFT_HDR: 16 bits captured. After the 16th rising edge, load `mem_addr` and `rw`. If `rw`=0 → RD_STROBE; else → SHIFT_DATA.
  - RD_STROBE: `msg_in`=1 for one clk → RD_WAIT.
  - RD_WAIT: count `READ_LAT` clk, latch `mem_read_out` into the tx shift register → SHIFT_DATA.
  - SHIFT_DATA: 8 bits. On reads, `miso` drives tx[7] first, from the first falling edge after the byte is latched. After the 24th rising edge: if `rw`=1 → WR_COMMIT; else → DONE.
  - WR_COMMIT: `coeff_in` loaded one clk before the strobe, then `msg_in`=1 with `rw`=1 for one clk → DONE.
  - DONE: wait for `cs_n` high → IDLE.
- `mem_addr`, `rw` and `coeff_in` hold their values from the strobe until the next frame loads new values.
- `cs_n` rising in any state before DONE aborts the frame → IDLE:
  - no write strobe is issued;
  - a read strobe already issued is not repeated;
  - the bit counter and shift registers are cleared.
- Bits beyond 24 within one `cs_n` low period are ignored; `miso`=0.
- `cs_n` falling while in DONE is not possible, since `cs_n` must be high to leave DONE. A new frame requires `cs_n` high for at least `SYNC_STAGES`+2 clk.

## Timing
- Reset values: `msg_in`=0, `rw`=0, `mem_addr`=0, `coeff_in`=0, `miso`=0, `addr_err`=0, FSM in IDLE, counters 0.
- Reset asserted mid-frame returns all outputs to their reset values immediately. The remainder of that frame is ignored until `cs_n` goes high.
- Edge-detect latency: `SYNC_STAGES`+1 clk from a pin edge.
- Read strobe: 1 clk after the 16th detected rising edge.
- Write strobe: 2 clk after the 24th detected rising edge; `coeff_in` is stable at least 1 clk before the strobe.
- `msg_in` is never high for more than 1 consecutive clk and pulses at most once per frame.
- Requirement on the SPI host: `sclk` half-period ≥ `READ_LAT`+`SYNC_STAGES`+3 clk. With the defaults this is ≥ 8 clk, i.e. `clk` ≥ 16× `sclk`.

## Configuration
- `SPI_CFG_ADDR_CHECK_EN` defined:
  - Writes are committed only when `mem_addr` lies in 128–198 (I coefficients) or 256–326 (Q coefficients).
  - Any other write address suppresses the strobe and sets `addr_err`=1. `addr_err` clears only on reset.
  - Reads are never checked.
- `SPI_CFG_ADDR_CHECK_EN` undefined:
  - All complete write frames strobe, regardless of address.
  - `addr_err` is tied to 0.

## Test plan
- Write frame: `rw`=1, addr=130, data=0x5A → exactly one `msg_in` pulse with `rw`=1, `mem_addr`=130, `coeff_in`=0x5A; all three hold afterwards.
- Read frame: addr=513, with the model returning 0xA5 `READ_LAT` clk after the strobe → one pulse with `rw`=0, `mem_addr`=513; `miso` bits 17–24 = 1,0,1,0,0,1,0,1.
- Abort: `cs_n` raised after 20 bits of a write frame to addr 140 → no `msg_in` pulse; the next full frame decodes correctly.
- Reset mid-frame: `rst_n` low after bit 10, released while `cs_n` is still low → all outputs 0; no strobe until a new frame after `cs_n` goes high.
- Back-to-back: frames to addr 256 with data 0x01 and addr 257 with data 0x02, `cs_n` high 2 `sclk` periods between them → two pulses, correct values in order.
- With `SPI_CFG_ADDR_CHECK_EN`: write to addr 200 → no pulse, `addr_err`=1; a following write to addr 128 → pulse issued, `addr_err` stays 1.

Source files
------------

// File: rtl/spi_cfg_slave.sv
// SPI mode-0 slave that turns 24-bit frames into memory access strobes for dsp_top.
// Optional write-address window check: define SPI_CFG_ADDR_CHECK_EN.
//
// state      | meaning
// IDLE       | waiting for cs_n falling edge
// SHIFT_HDR  | shifting in rw + reserved + 10-bit address
// RD_STROBE  | msg_in high for the read access
// RD_WAIT    | counting READ_LAT clk until mem_read_out is valid
// SHIFT_DATA | shifting 8 data bits in (write) or out on miso (read)
// WR_COMMIT  | coeff_in stable; issue the write strobe
// DONE       | frame complete, waiting for cs_n high
`timescale 1ns/1ps
module spi_cfg_slave #(
  parameter int READ_LAT    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] mem_read_out,
  output logic       msg_in,
  output logic       rw,
  output logic [9:0] mem_addr,
  output logic [7:0] coeff_in,
  output logic       addr_err
);

  localparam int WW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT);

  typedef enum logic [2:0] {
    IDLE, SHIFT_HDR, RD_STROBE, RD_WAIT, SHIFT_DATA, WR_COMMIT, DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [4:0]             bit_cnt;
  logic [15:0]            rx_sh;
  logic [15:0]            rx_next;
  logic [7:0]             tx_sh;
  logic [WW-1:0]          wait_cnt;
  logic                   addr_ok;

  // cs_n chain resets to "low" so a frame already in progress at reset release
  // never produces a falling edge; a real cs_n high period is needed first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign rx_next   = {rx_sh[14:0], mosi_s};

`ifdef SPI_CFG_ADDR_CHECK_EN
  assign addr_ok = (mem_addr >= 10'd128 && mem_addr <= 10'd198) ||
                   (mem_addr >= 10'd256 && mem_addr <= 10'd326);
`else
  assign addr_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_sh    <= '0;
      tx_sh    <= '0;
      wait_cnt <= '0;
      miso     <= 1'b0;
      msg_in   <= 1'b0;
      rw       <= 1'b0;
      mem_addr <= '0;
      coeff_in <= '0;
      addr_err <= 1'b0;
    end else begin
      msg_in <= 1'b0;
      if (cs_rise && state != IDLE && state != DONE) begin
        state   <= IDLE;
        bit_cnt <= '0;
        rx_sh   <= '0;
        tx_sh   <= '0;
        miso    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            if (cs_fall) begin
              state   <= SHIFT_HDR;
              bit_cnt <= '0;
              rx_sh   <= '0;
              tx_sh   <= '0;
            end
          end
          SHIFT_HDR: begin
            if (sclk_rise) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                rw       <= rx_next[15];
                mem_addr <= rx_next[9:0];
                if (rx_next[15]) begin
                  state <= SHIFT_DATA;
                end else begin
                  state  <= RD_STROBE;
                  msg_in <= 1'b1;
                end
              end
            end
          end
          RD_STROBE: begin
            wait_cnt <= WW'(READ_LAT - 1);
            state    <= RD_WAIT;
          end
          RD_WAIT: begin
            if (wait_cnt == '0) begin
              tx_sh <= mem_read_out;
              state <= SHIFT_DATA;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          SHIFT_DATA: begin
            if (sclk_fall) begin
              miso  <= tx_sh[7];
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                if (rw) begin
                  coeff_in <= rx_next[7:0];
                  state    <= WR_COMMIT;
                end else begin
                  state <= DONE;
                end
              end
            end
          end
          WR_COMMIT: begin
            state <= DONE;
            if (addr_ok) msg_in   <= 1'b1;
            else         addr_err <= 1'b1;
          end
          DONE: begin
            miso <= 1'b0;
            if (cs_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Directed bench for spi_cfg_slave: writes, reads, abort, mid-frame reset, back-to-back frames.
`timescale 1ns/1ps
module tb_spi_cfg_slave;
  localparam int READ_LAT    = 3;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] mem_read_out;
  logic       msg_in;
  logic       rw;
  logic [9:0] mem_addr;
  logic [7:0] coeff_in;
  logic       addr_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_cfg_slave #(.READ_LAT(READ_LAT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_read_out(mem_read_out), .msg_in(msg_in), .rw(rw), .mem_addr(mem_addr),
    .coeff_in(coeff_in), .addr_err(addr_err)
  );

  // memory model: read data is valid only READ_LAT clk after the read strobe
  int         rd_cnt = 0;
  logic [7:0] rd_data = 8'h00;
  always @(posedge clk) begin
    if (msg_in && !rw) rd_cnt <= READ_LAT;
    else if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
  end
  assign mem_read_out = (rd_cnt == 1) ? rd_data : 8'h00;

  int         pulse_cnt = 0;
  int         multi_pulse = 0;
  int         coeff_unstable = 0;
  logic       msg_prev = 1'b0;
  logic [7:0] coeff_prev = 8'h00;
  logic [9:0] p_addr [64];
  logic       p_rw [64];
  logic [7:0] p_coeff [64];
  always @(posedge clk) begin
    if (msg_in) begin
      if (pulse_cnt < 64) begin
        p_addr[pulse_cnt]  <= mem_addr;
        p_rw[pulse_cnt]    <= rw;
        p_coeff[pulse_cnt] <= coeff_in;
      end
      pulse_cnt <= pulse_cnt + 1;
      if (msg_prev) multi_pulse <= multi_pulse + 1;
      if (rw && coeff_in !== coeff_prev) coeff_unstable <= coeff_unstable + 1;
    end
    msg_prev   <= msg_in;
    coeff_prev <= coeff_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic w, input logic [9:0] a, input logic [7:0] d);
    return {w, 5'b00000, a, d};
  endfunction

  task automatic cs_low();
    cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic xfer_bit(input logic b, output logic m);
    mosi = b;
    #(HALF);
    sclk = 1'b1;
    m = miso;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic cs_high();
    #(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    #(4*HALF);
  endtask

  task automatic frame(input logic [23:0] f, input int nbits, output logic [23:0] rx);
    logic m;
    rx = '0;
    cs_low();
    for (int i = 0; i < nbits; i++) begin
      xfer_bit(f[23-i], m);
      rx[23-i] = m;
    end
    cs_high();
  endtask

  logic [23:0] rx;
  logic [23:0] f;
  logic        m;
  int          base;

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_msg_in", msg_in, 0);
    check("rst_rw", rw, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_coeff_in", coeff_in, 0);
    check("rst_miso", miso, 0);
    check("rst_addr_err", addr_err, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    base = pulse_cnt;
    frame(mk(1'b1, 10'd130, 8'h5A), 24, rx);
    @(negedge clk);
    check("wr_pulses", pulse_cnt - base, 1);
    check("wr_rw", p_rw[base], 1);
    check("wr_addr", p_addr[base], 130);
    check("wr_coeff", p_coeff[base], 8'h5A);
    check("wr_hold_addr", mem_addr, 130);
    check("wr_hold_coeff", coeff_in, 8'h5A);
    check("wr_hold_rw", rw, 1);
    check("wr_msg_low", msg_in, 0);

    rd_data = 8'hA5;
    base = pulse_cnt;
    frame(mk(1'b0, 10'd513, 8'h00), 24, rx);
    @(negedge clk);
    check("rd_pulses", pulse_cnt - base, 1);
    check("rd_rw", p_rw[base], 0);
    check("rd_addr", p_addr[base], 513);
    check("rd_miso_data", rx[7:0], 8'hA5);
    check("rd_miso_hdr", rx[23:8], 0);
    check("rd_miso_idle", miso, 0);

    base = pulse_cnt;
    frame(mk(1'b1, 10'd140, 8'h33), 20, rx);
    @(negedge clk);
    check("abort_pulses", pulse_cnt - base, 0);
    frame(mk(1'b1, 10'd198, 8'h3C), 24, rx);
    @(negedge clk);
    check("post_abort_pulses", pulse_cnt - base, 1);
    check("post_abort_addr", p_addr[base], 198);
    check("post_abort_coeff", p_coeff[base], 8'h3C);

    base = pulse_cnt;
    f = mk(1'b1, 10'd150, 8'h77);
    cs_low();
    for (int i = 0; i < 10; i++) xfer_bit(f[23-i], m);
    rst_n = 1'b0;
    #(30);
    check("midrst_addr", mem_addr, 0);
    check("midrst_coeff", coeff_in, 0);
    check("midrst_rw", rw, 0);
    check("midrst_msg", msg_in, 0);
    check("midrst_miso", miso, 0);
    rst_n = 1'b1;
    for (int i = 10; i < 24; i++) xfer_bit(f[23-i], m);
    cs_high();
    @(negedge clk);
    check("midrst_pulses", pulse_cnt - base, 0);
    check("midrst_addr_after", mem_addr, 0);
    frame(mk(1'b1, 10'd131, 8'h11), 24, rx);
    @(negedge clk);
    check("midrst_next_pulses", pulse_cnt - base, 1);
    check("midrst_next_addr", p_addr[base], 131);

    base = pulse_cnt;
    frame(mk(1'b1, 10'd256, 8'h01), 24, rx);
    frame(mk(1'b1, 10'd257, 8'h02), 24, rx);
    @(negedge clk);
    check("b2b_pulses", pulse_cnt - base, 2);
    check("b2b_addr0", p_addr[base], 256);
    check("b2b_coeff0", p_coeff[base], 8'h01);
    check("b2b_addr1", p_addr[base+1], 257);
    check("b2b_coeff1", p_coeff[base+1], 8'h02);

    base = pulse_cnt;
    frame(mk(1'b1, 10'd200, 8'h44), 24, rx);
    @(negedge clk);
`ifdef SPI_CFG_ADDR_CHECK_EN
    check("chk_bad_pulses", pulse_cnt - base, 0);
    check("chk_bad_err", addr_err, 1);
    frame(mk(1'b1, 10'd128, 8'h55), 24, rx);
    @(negedge clk);
    check("chk_good_pulses", pulse_cnt - base, 1);
    check("chk_good_addr", p_addr[base], 128);
    check("chk_good_err", addr_err, 1);
`else
    check("nochk_pulses", pulse_cnt - base, 1);
    check("nochk_addr", p_addr[base], 200);
    check("nochk_err", addr_err, 0);
`endif

    check("multi_pulse", multi_pulse, 0);
    check("coeff_unstable", coeff_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
